pmem_arbiter_rr: RTL
====================

Name: pmem_arbiter_rr

Overview:
N-port arbiter between the L1 caches (instruction, data, later prefetch/victim) and the single physical-memory line port. Each transaction is one burst-line read or write, held until pmem responds. Request fields are captured into a buffer at grant, so pmem sees stable inputs. Default policy is round-robin, which gives fairness the two-port predecessor lacked.

Parameters:
NUM_PORTS, 2, number of cache requesters (>=2); port 0 is instruction cache
ADDR_WIDTH, 32, line address width
LINE_WIDTH, 256, cache line width in bits
IDX_WIDTH, $clog2(NUM_PORTS), grant index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
port_address  in  NUM_PORTS*ADDR_WIDTH  per-port line address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
port_wdata  in  NUM_PORTS*LINE_WIDTH  per-port write line
port_read  in  NUM_PORTS  per-port read request
port_write  in  NUM_PORTS  per-port write request
port_rdata  out  NUM_PORTS*LINE_WIDTH  per-port read line
port_resp  out  NUM_PORTS  per-port one-cycle response
cache_address  out  ADDR_WIDTH  address to pmem
cache_to_pmem  out  LINE_WIDTH  write line to pmem
cache_read  out  1  pmem read strobe
cache_write  out  1  pmem write strobe
pmem_to_cache  in  LINE_WIDTH  read line from pmem
cache_resp  in  1  pmem completion
grant_idx  out  IDX_WIDTH  currently owning port
busy  out  1  transaction in flight

Behaviour:
- States: IDLE, ISSUE. All state, buffer and pointer flops reset asynchronously when rst=0.
- Reset values: state=IDLE; cache_read=cache_write=0; cache_address=0; cache_to_pmem=0; port_resp=0; port_rdata=0; grant_idx=0; busy=0; rr pointer=0.
- IDLE: req[i] = port_read[i] | port_write[i]. If any req, choose a winner W. Round-robin order starts at the rr pointer and scans indices upward mod NUM_PORTS. On the next edge, latch address[W], wdata[W], op (write if port_write[W], else read) into the buffer. Also set grant_idx=W, busy=1, state=ISSUE.
- If a port asserts read and write together, it is treated as a write; the bench flags this as a protocol error.
- ISSUE: cache_address/cache_to_pmem are driven from the buffer. Exactly one of cache_read/cache_write is 1, per the latched op; both are registered outputs. Port inputs are ignored; mid-transaction changes have no effect.
- ISSUE with cache_resp=1 (same cycle, combinational):
  - port_resp[grant_idx]=1.
  - port_rdata[grant_idx]=pmem_to_cache on reads; it is 0 on writes.
  - All other ports read resp=0, rdata=0.
- On that edge: state=IDLE, busy=0, strobes=0, rr pointer=(grant_idx+1) mod NUM_PORTS.
- port_resp is never high outside ISSUE.
- Latency: request seen in IDLE cycle t; strobe high from t+1; resp in the cycle pmem raises cache_resp. Minimum total is 2 cycles.
- Requesters must drop read/write in the cycle after their resp. The arbiter samples again in IDLE; one idle cycle separates back-to-back grants.
- Simultaneous requests: exactly one grant. Losers hold their requests and are served in rotation. With N requesters all continuously requesting, each is served within N transactions (no starvation).
- Pointer wrap: after grant NUM_PORTS-1, the pointer returns to 0.
- Reset mid-ISSUE: strobes drop immediately with rst=0 and the transaction is abandoned. No resp is issued.
- A cache_resp arriving in IDLE is ignored.

Optional Feature:
PMEM_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins (port 0, the instruction cache, always first). The rr pointer is not implemented; starvation of high indices is allowed.
- Undefined (default): round-robin as described above.

Test Plan:
- Single read: port1 read addr 0x0000_1040, pmem resp after 3 cycles with line 0xA5.. -> cache_read=1 at t+1, cache_address=0x0000_1040, port_resp[1]=1 with rdata=0xA5.., port_resp[0]=0.
- Simultaneous: ports 0 and 1 read at reset (ptr=0) -> port0 served first, then port1. A repeat collision is served port1 first (RR); with PMEM_ARB_FIXED_PRIO_EN, port0 first both times.
- Write: port0 write addr 0x0000_2000, wdata=all 1s; inputs change during ISSUE -> pmem sees the original address/data, cache_write=1, port_resp[0]=1 with rdata=0.
- Fairness NUM_PORTS=4: all four request continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
- Reset mid-ISSUE: drop rst to 0 while cache_read=1 -> cache_read=0 immediately, busy=0, no port_resp. After release, a new request is granted normally.
- Stray cache_resp in IDLE -> all port_resp stay 0, state unchanged.

Source files
------------

// File: rtl/pmem_arbiter_rr_if.sv
// Bus bundle between the L1 line requesters, the pmem arbiter and the physical-memory line port.
interface pmem_arbiter_rr_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
);
    logic [NUM_PORTS*ADDR_WIDTH-1:0] port_address;
    logic [NUM_PORTS*LINE_WIDTH-1:0] port_wdata;
    logic [NUM_PORTS-1:0]            port_read;
    logic [NUM_PORTS-1:0]            port_write;
    logic [NUM_PORTS*LINE_WIDTH-1:0] port_rdata;
    logic [NUM_PORTS-1:0]            port_resp;
    logic [ADDR_WIDTH-1:0]           cache_address;
    logic [LINE_WIDTH-1:0]           cache_to_pmem;
    logic                            cache_read;
    logic                            cache_write;
    logic [LINE_WIDTH-1:0]           pmem_to_cache;
    logic                            cache_resp;

    // Arbiter view
    modport slave (
        input  port_address, port_wdata, port_read, port_write, pmem_to_cache, cache_resp,
        output port_rdata, port_resp, cache_address, cache_to_pmem, cache_read, cache_write
    );

    // Requesters plus pmem view
    modport master (
        output port_address, port_wdata, port_read, port_write, pmem_to_cache, cache_resp,
        input  port_rdata, port_resp, cache_address, cache_to_pmem, cache_read, cache_write
    );
endinterface

// File: rtl/pmem_arbiter_rr.sv
// N-port arbiter of L1 line requests onto a single pmem line port; one burst line per grant.
// Default is round-robin; define PMEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module pmem_arbiter_rr #(
    parameter int unsigned  NUM_PORTS  = 2,
    parameter int unsigned  ADDR_WIDTH = 32,
    parameter int unsigned  LINE_WIDTH = 256,
    localparam int unsigned IDX_WIDTH  = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    pmem_arbiter_rr_if.slave     bus,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 busy
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [NUM_PORTS-1:0] req;
    logic [IDX_WIDTH-1:0] win_idx;
    logic                 win_vld;
    logic                 grant_load;
    logic                 done;

    // A port asserting read and write together counts as a single (write) request
    assign req = bus.port_read | bus.port_write;

`ifdef PMEM_ARB_FIXED_PRIO_EN
    // Lowest requesting index wins
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = IDX_WIDTH'(i);
                win_vld = 1'b1;
            end
        end
    end
`else
    logic [IDX_WIDTH-1:0] rr_ptr;

    // First requester found scanning upward from the pointer, wrapping at NUM_PORTS
    always_comb begin
        int unsigned idx;
        idx     = 0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_PORTS;
            if (!win_vld && req[IDX_WIDTH'(idx)]) begin
                win_idx = IDX_WIDTH'(idx);
                win_vld = 1'b1;
            end
        end
    end

    // Pointer moves just past the port that completed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (done) begin
            rr_ptr <= (32'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the same-cycle response steering back to the owning port
    always_comb begin
        state_d        = state_q;
        grant_load     = 1'b0;
        done           = 1'b0;
        bus.port_resp  = '0;
        bus.port_rdata = '0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    grant_load = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.cache_resp) begin
                    done                     = 1'b1;
                    state_d                  = IDLE;
                    bus.port_resp[grant_idx] = 1'b1;
                    if (bus.cache_read) begin
                        bus.port_rdata[32'(grant_idx)*LINE_WIDTH +: LINE_WIDTH] = bus.pmem_to_cache;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request buffer: captured at grant so pmem sees stable fields for the whole burst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.cache_address <= '0;
            bus.cache_to_pmem <= '0;
            bus.cache_read    <= 1'b0;
            bus.cache_write   <= 1'b0;
            grant_idx         <= '0;
            busy              <= 1'b0;
        end else if (grant_load) begin
            bus.cache_address <= bus.port_address[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.cache_to_pmem <= bus.port_wdata[32'(win_idx)*LINE_WIDTH +: LINE_WIDTH];
            bus.cache_write   <= bus.port_write[win_idx];
            bus.cache_read    <= ~bus.port_write[win_idx];
            grant_idx         <= win_idx;
            busy              <= 1'b1;
        end else if (done) begin
            bus.cache_read    <= 1'b0;
            bus.cache_write   <= 1'b0;
            busy              <= 1'b0;
        end
    end
endmodule
